// File: rtl/operand_fetch.sv
// Operand fetch / issue stage: regfile read with write-back bypass, a pending-write
// scoreboard that stalls on RAW/WAW hazards, and a registered valid/ready output slot.
module operand_fetch #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_pc,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic [4:0]      in_rd,
    input  logic            in_wr_rd,
    output logic [4:0]      rf_addr_a,
    output logic [4:0]      rf_addr_b,
    input  logic [BITS-1:0] rf_data_a,
    input  logic [BITS-1:0] rf_data_b,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [BITS-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_pc,
    output logic [BITS-1:0] out_op_a,
    output logic [BITS-1:0] out_op_b,
    output logic [4:0]      out_rd,
    output logic            out_wr_rd
);

    logic [31:0]     pend_q, pend_d;
    logic            valid_q, valid_d;
    logic [BITS-1:0] pc_q, pc_d, op_a_q, op_a_d, op_b_q, op_b_d;
    logic [4:0]      rd_q, rd_d;
    logic            wr_rd_q, wr_rd_d;

    logic hz1, hz2, hzw, accept, flush_clr;

    // x0 reads as zero; the regfile lags the write-back by one edge, so bypass it.
    function automatic logic [BITS-1:0] operand_sel(
        input logic [4:0]      rs,
        input logic [BITS-1:0] rf_val,
        input logic            wen,
        input logic [4:0]      waddr,
        input logic [BITS-1:0] wdata
    );
        if (rs == 5'd0)
            return '0;
        else if (wen && (waddr == rs))
            return wdata;
        else
            return rf_val;
    endfunction

    assign rf_addr_a = in_rs1;
    assign rf_addr_b = in_rs2;

    assign hz1 = in_use_rs1 && (in_rs1 != 5'd0) && pend_q[in_rs1] && !(wb_en && (wb_addr == in_rs1));
    assign hz2 = in_use_rs2 && (in_rs2 != 5'd0) && pend_q[in_rs2] && !(wb_en && (wb_addr == in_rs2));
    assign hzw = in_wr_rd && (in_rd != 5'd0) && pend_q[in_rd];

    assign in_ready  = !rst && !flush && !(hz1 || hz2 || hzw) && (!valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    // A held instruction killed before execute took it will never write back.
    assign flush_clr = flush && valid_q && !out_ready && wr_rd_q && (rd_q != 5'd0);

    always_comb begin
        pend_d = pend_q;
        if (wb_en)
            pend_d[wb_addr] = 1'b0;
        if (flush_clr)
            pend_d[rd_q] = 1'b0;
        if (accept && in_wr_rd && (in_rd != 5'd0))
            pend_d[in_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        rd_d    = rd_q;
        wr_rd_d = wr_rd_q;
        if (accept) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            op_a_d  = operand_sel(in_rs1, rf_data_a, wb_en, wb_addr, wb_data);
            op_b_d  = operand_sel(in_rs2, rf_data_b, wb_en, wb_addr, wb_data);
            rd_d    = in_rd;
            wr_rd_d = in_wr_rd;
        end else if (flush || out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            rd_q    <= '0;
            wr_rd_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            rd_q    <= rd_d;
            wr_rd_q <= wr_rd_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_op_a  = op_a_q;
    assign out_op_b  = op_b_q;
    assign out_rd    = rd_q;
    assign out_wr_rd = wr_rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: operand-selection table, directed hazard/flush/backpressure
// sequences and randomized traffic, all checked against a behavioural model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_use_rs1, in_use_rs2, in_wr_rd;
    logic [31:0] in_pc, rf_data_a, rf_data_b, wb_data;
    logic [4:0]  in_rs1, in_rs2, in_rd, rf_addr_a, rf_addr_b, wb_addr, out_rd;
    logic        wb_en, flush, out_valid, out_ready, out_wr_rd;
    logic [31:0] out_pc, out_op_a, out_op_b;

    logic [31:0] regs [32];
    assign rf_data_a = regs[rf_addr_a];
    assign rf_data_b = regs[rf_addr_b];

    always #5 clk = ~clk;

    operand_fetch #(.BITS(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_wr_rd(in_wr_rd), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rd(out_rd),
        .out_wr_rd(out_wr_rd)
    );

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    bit          m_pend [32];
    bit          m_vld, m_wr;
    logic [31:0] m_pc, m_a, m_b;
    logic [4:0]  m_rd;
    logic        last_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 0;
        in_use_rs2 = 0; in_rd = 0; in_wr_rd = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd, input logic wr);
        in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
        in_use_rs1 = u1; in_use_rs2 = u2; in_rd = rd; in_wr_rd = wr;
    endtask

    function automatic logic [31:0] opnd(input logic [4:0] rs);
        if (rs == 0) return 32'h0;
        if (wb_en && wb_addr == rs) return wb_data;
        return regs[rs];
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic tick();
        bit          h1, h2, hw, er, acc;
        bit          np [32];
        bit          nv, nw;
        logic [31:0] npc, na, nb;
        logic [4:0]  nrd;
        #1;
        h1 = in_use_rs1 && in_rs1 != 0 && m_pend[in_rs1] && !(wb_en && wb_addr == in_rs1);
        h2 = in_use_rs2 && in_rs2 != 0 && m_pend[in_rs2] && !(wb_en && wb_addr == in_rs2);
        hw = in_wr_rd && in_rd != 0 && m_pend[in_rd];
        er = !rst && !flush && !(h1 || h2 || hw) && (!m_vld || out_ready);
        last_rdy = in_ready;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("rf_addr_a", 32'(rf_addr_a), 32'(in_rs1));
        chk("rf_addr_b", 32'(rf_addr_b), 32'(in_rs2));
        acc = in_valid && er;
        np = m_pend; nv = m_vld; nw = m_wr; npc = m_pc; na = m_a; nb = m_b; nrd = m_rd;
        if (rst) begin
            foreach (np[i]) np[i] = 0;
            nv = 0; nw = 0; npc = 0; na = 0; nb = 0; nrd = 0;
        end else begin
            if (wb_en) np[wb_addr] = 0;
            if (flush && m_vld && !out_ready && m_wr && m_rd != 0) np[m_rd] = 0;
            if (acc && in_wr_rd && in_rd != 0) np[in_rd] = 1;
            np[0] = 0;
            if (acc) begin
                nv = 1; npc = in_pc; na = opnd(in_rs1); nb = opnd(in_rs2);
                nrd = in_rd; nw = in_wr_rd;
            end else if (flush || out_ready) begin
                nv = 0;
            end
        end
        @(negedge clk);
        if (!rst && wb_en && wb_addr != 0) regs[wb_addr] = wb_data;
        m_pend = np; m_vld = nv; m_wr = nw; m_pc = npc; m_a = na; m_b = nb; m_rd = nrd;
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        chk("out_pc", out_pc, m_pc);
        chk("out_op_a", out_op_a, m_a);
        chk("out_op_b", out_op_b, m_b);
        chk("out_rd", 32'(out_rd), 32'(m_rd));
        chk("out_wr_rd", 32'(out_wr_rd), 32'(m_wr));
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata, exp_a, exp_b;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // regs[0] deliberately non-zero: x0 must read as zero through the stage
        foreach (regs[i]) regs[i] = 32'h1000_0000 + i;
        regs[0] = 32'hdeadbeef;
        foreach (m_pend[i]) m_pend[i] = 0;
        m_vld = 0; m_wr = 0; m_pc = 0; m_a = 0; m_b = 0; m_rd = 0;

        vecs[0] = '{5'd1, 5'd2, 1'b0, 5'd0, 32'h0,          32'h1000_0001, 32'h1000_0002};
        vecs[1] = '{5'd0, 5'd0, 1'b1, 5'd0, 32'h1234_5678,  32'h0,         32'h0};
        vecs[2] = '{5'd1, 5'd4, 1'b1, 5'd1, 32'haabb_ccdd,  32'haabb_ccdd, 32'h1000_0004};
        vecs[3] = '{5'd3, 5'd3, 1'b1, 5'd3, 32'h0000_0055,  32'h0000_0055, 32'h0000_0055};
        vecs[4] = '{5'd4, 5'd5, 1'b1, 5'd5, 32'h0000_cafe,  32'h1000_0004, 32'h0000_cafe};
        vecs[5] = '{5'd0, 5'd6, 1'b1, 5'd0, 32'h0000_0077,  32'h0,         32'h1000_0006};

        idle();
        @(negedge clk);

        // reset for two cycles, then an x0/x0 issue
        rst = 1;
        tick(); tick();
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_pc", out_pc, 32'h0);
        rst = 0;
        issue(32'h40, 5'd0, 5'd0, 1, 1, 5'd0, 0);
        tick();
        chk("x0_op_a", out_op_a, 32'h0);
        chk("x0_op_b", out_op_b, 32'h0);

        // operand selection table
        for (int i = 0; i < 6; i++) begin
            idle();
            issue(32'h80 + 32'(i * 4), vecs[i].rs1, vecs[i].rs2, 1, 1, 5'd0, 0);
            wb_en = vecs[i].wen; wb_addr = vecs[i].waddr; wb_data = vecs[i].wdata;
            tick();
            chk("tbl_valid", 32'(out_valid), 32'h1);
            chk("tbl_op_a", out_op_a, vecs[i].exp_a);
            chk("tbl_op_b", out_op_b, vecs[i].exp_b);
        end

        // RAW on rs2, released by the same-cycle write-back
        idle(); issue(32'h100, 5'd0, 5'd0, 0, 0, 5'd2, 1); tick();
        idle(); issue(32'h104, 5'd0, 5'd2, 0, 1, 5'd0, 0); tick();
        chk("raw_stall", 32'(last_rdy), 32'h0);
        tick();
        chk("raw_stall2", 32'(last_rdy), 32'h0);
        wb_en = 1; wb_addr = 5'd2; wb_data = 32'hffffffff; tick();
        chk("raw_release", 32'(last_rdy), 32'h1);
        chk("raw_op_b", out_op_b, 32'hffffffff);

        // WAW on rd=3: the write-back cycle itself stays stalled
        idle(); issue(32'h200, 5'd0, 5'd0, 0, 0, 5'd3, 1); tick();
        idle(); issue(32'h204, 5'd0, 5'd0, 0, 0, 5'd3, 1); tick();
        chk("waw_stall", 32'(last_rdy), 32'h0);
        wb_en = 1; wb_addr = 5'd3; wb_data = 32'h33; tick();
        chk("waw_wb_stall", 32'(last_rdy), 32'h0);
        wb_en = 0; tick();
        chk("waw_release", 32'(last_rdy), 32'h1);
        idle(); issue(32'h208, 5'd3, 5'd0, 1, 0, 5'd0, 0); tick();
        chk("waw_repend", 32'(last_rdy), 32'h0);
        wb_en = 1; wb_addr = 5'd3; wb_data = 32'h34; tick();

        // backpressure
        idle(); issue(32'h500, 5'd1, 5'd2, 1, 1, 5'd0, 0); tick();
        issue(32'h504, 5'd4, 5'd5, 1, 1, 5'd0, 0); out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall", 32'(last_rdy), 32'h0);
            chk("bp_hold_pc", out_pc, 32'h500);
        end
        out_ready = 1; tick();
        chk("bp_resume_pc", out_pc, 32'h504);

        // flush of a held, untaken instruction with rd=5
        idle(); issue(32'h600, 5'd0, 5'd0, 0, 0, 5'd5, 1); tick();
        issue(32'h604, 5'd0, 5'd0, 0, 0, 5'd6, 1); out_ready = 0; flush = 1; tick();
        chk("flush_ready", 32'(last_rdy), 32'h0);
        chk("flush_valid", 32'(out_valid), 32'h0);
        idle(); issue(32'h608, 5'd5, 5'd6, 1, 1, 5'd0, 0); tick();
        chk("flush_pend_clr", 32'(last_rdy), 32'h1);

        // reset during a stall
        idle(); issue(32'h700, 5'd0, 5'd0, 0, 0, 5'd7, 1); tick();
        idle(); issue(32'h704, 5'd7, 5'd0, 1, 0, 5'd0, 0); tick();
        chk("rst_stall", 32'(last_rdy), 32'h0);
        rst = 1; tick();
        rst = 0; tick();
        chk("rst_release", 32'(last_rdy), 32'h1);

        // randomized traffic on a small register window to provoke hazards
        for (int c = 0; c < 600; c++) begin
            int pl [$];
            idle();
            in_valid   = ($urandom_range(3) != 0);
            in_pc      = $urandom;
            in_rs1     = 5'($urandom_range(7));
            in_rs2     = 5'($urandom_range(7));
            in_use_rs1 = 1'($urandom_range(1));
            in_use_rs2 = 1'($urandom_range(1));
            in_rd      = 5'($urandom_range(7));
            in_wr_rd   = 1'($urandom_range(1));
            out_ready  = ($urandom_range(9) < 7);
            flush      = ($urandom_range(19) == 0);
            rst        = ($urandom_range(99) == 0);
            for (int r = 1; r < 32; r++) if (m_pend[r]) pl.push_back(r);
            if ($urandom_range(1) == 1) begin
                wb_en   = 1;
                wb_data = $urandom;
                if (pl.size() > 0 && $urandom_range(3) != 0)
                    wb_addr = 5'(pl[$urandom_range(pl.size() - 1)]);
                else
                    wb_addr = 5'($urandom_range(7));
            end
            tick();
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
